// File: rtl/risc16_pkg.sv
// Shared encodings for the RISC16 multi-cycle control unit.
// Covers opcodes, FSM states, datapath mux selects and the decoded control word.
package risc16_pkg;

    localparam int unsigned IR_W   = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_NAND = 2'b01,
        ALU_PASS = 2'b10,
        ALU_EQ   = 2'b11
    } func_alu_e;

    typedef enum logic [1:0] {
        TGT_MEM = 2'b00,
        TGT_ALU = 2'b01,
        TGT_PC  = 2'b10
    } mux_tgt_e;

    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_REL = 2'b01,
        PC_REG = 2'b10
    } mux_pc_e;

    // Per-opcode control word; constant for the lifetime of one instruction.
    typedef struct packed {
        func_alu_e func_alu;
        logic      mux_alu2;
        mux_tgt_e  mux_tgt;
        logic      mux_rf;
        mux_pc_e   mux_pc;
        logic      is_mem;
        logic      is_sw;
        logic      is_beq;
        logic      is_jalr;
    } ctrl_t;

endpackage

// File: rtl/risc16_decode.sv
// Combinational opcode decoder: maps the latched opcode to its control word.
module risc16_decode
    import risc16_pkg::*;
(
    input  opcode_e opcode,
    output ctrl_t   ctrl
);

    always_comb begin
        ctrl          = '0;
        ctrl.func_alu = ALU_ADD;
        ctrl.mux_tgt  = TGT_ALU;
        ctrl.mux_pc   = PC_INC;
        case (opcode)
            OP_ADD: begin
            end
            OP_ADDI: begin
                ctrl.mux_alu2 = 1'b1;
            end
            OP_NAND: begin
                ctrl.func_alu = ALU_NAND;
            end
            OP_LUI: begin
                ctrl.func_alu = ALU_PASS;
                ctrl.mux_alu2 = 1'b1;
            end
            OP_SW: begin
                ctrl.mux_alu2 = 1'b1;
                ctrl.mux_rf   = 1'b1;
                ctrl.is_mem   = 1'b1;
                ctrl.is_sw    = 1'b1;
            end
            OP_LW: begin
                ctrl.mux_alu2 = 1'b1;
                ctrl.mux_tgt  = TGT_MEM;
                ctrl.is_mem   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.func_alu = ALU_EQ;
                ctrl.mux_rf   = 1'b1;
                ctrl.mux_pc   = PC_REL;
                ctrl.is_beq   = 1'b1;
            end
            OP_JALR: begin
                ctrl.mux_tgt  = TGT_PC;
                ctrl.mux_pc   = PC_REG;
                ctrl.is_jalr  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/risc16_control.sv
// Multi-cycle RISC16 control unit: Moore FSM, instruction register and
// retired-instruction counter driving the datapath selects and memory strobes.
module risc16_control
    import risc16_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter bit          HALT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IR_W-1:0]    ir_in,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               alu_eq,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               WE_rf,
    output logic               MUX_rf,
    output logic [SEL_W-1:0]   MUX_tgt,
    output logic               WE_pc,
    output logic [SEL_W-1:0]   MUX_pc,
    output logic [SEL_W-1:0]   FUNC_alu,
    output logic               MUX_alu2,
    output logic [REG_W-1:0]   rA,
    output logic [REG_W-1:0]   rB,
    output logic [REG_W-1:0]   rC,
    output logic [IR_W-1:0]    simm7,
    output logic [IR_W-1:0]    imm10,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    state_e           state;
    state_e           state_nxt;
    logic [IR_W-1:0]  ir;
    ctrl_t            ctrl;
    logic             retire;
    logic             halt_req;

    risc16_decode u_decode (
        .opcode (opcode_e'(ir[15:13])),
        .ctrl   (ctrl)
    );

    assign rA       = ir[12:10];
    assign rB       = ir[9:7];
    assign rC       = ir[2:0];
    assign simm7    = {{9{ir[6]}}, ir[6:0]};
    assign imm10    = {ir[9:0], 6'b0};
    assign halt_req = HALT_EN && ctrl.is_jalr && (ir[6:0] != 7'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = halt_req ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                if (ctrl.is_beq) begin
                    state_nxt = ST_FETCH;
                end else if (ctrl.is_mem) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_nxt = ctrl.is_sw ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // Output decode; strobes are masked while rst is held so nothing fires during reset.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        WE_rf    = 1'b0;
        WE_pc    = 1'b0;
        MUX_pc   = PC_INC;
        retire   = 1'b0;
        halted   = 1'b0;
        MUX_rf   = ctrl.mux_rf;
        MUX_tgt  = ctrl.mux_tgt;
        FUNC_alu = ctrl.func_alu;
        MUX_alu2 = ctrl.mux_alu2;
        case (state)
            ST_FETCH: begin
                imem_req = !rst;
                WE_pc    = imem_ready && !rst;
            end
            ST_DECODE: begin
            end
            ST_EXEC: begin
                MUX_pc = ctrl.mux_pc;
                if (ctrl.is_beq) begin
                    WE_pc  = alu_eq && !rst;
                    retire = 1'b1;
                end
            end
            ST_MEM: begin
                MUX_pc   = ctrl.mux_pc;
                dmem_req = !rst;
                dmem_we  = ctrl.is_sw && !rst;
                retire   = ctrl.is_sw && dmem_ready;
            end
            ST_WB: begin
                MUX_pc = ctrl.mux_pc;
                WE_rf  = (ir[12:10] != 3'd0) && !rst;
                WE_pc  = ctrl.is_jalr && !rst;
                retire = 1'b1;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Instruction register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ir          <= '0;
            instr_count <= '0;
        end else begin
            if (state == ST_FETCH && imem_ready) begin
                ir <= ir_in;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_risc16_control.sv
// Directed bench for risc16_control; a narrow-counter, halt-disabled twin
// shares the stimulus to exercise counter wrap and the HALT_EN=0 path.
module tb_risc16_control;

    logic        clk;
    logic        rst;
    logic [15:0] ir_in;
    logic        imem_ready;
    logic        dmem_ready;
    logic        alu_eq;

    logic        imem_req, dmem_req, dmem_we, WE_rf, MUX_rf, WE_pc, MUX_alu2, halted;
    logic [1:0]  MUX_tgt, MUX_pc, FUNC_alu;
    logic [2:0]  rA, rB, rC;
    logic [15:0] simm7, imm10, instr_count;

    logic        imem_req4, dmem_req4, dmem_we4, WE_rf4, MUX_rf4, WE_pc4, MUX_alu24, halted4;
    logic [1:0]  MUX_tgt4, MUX_pc4, FUNC_alu4;
    logic [2:0]  rA4, rB4, rC4;
    logic [15:0] simm74, imm104;
    logic [3:0]  instr_count4;

    int tests;
    int fails;
    int req_cycles;

    risc16_control dut (
        .clk(clk), .rst(rst), .ir_in(ir_in), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .alu_eq(alu_eq),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .WE_rf(WE_rf), .MUX_rf(MUX_rf), .MUX_tgt(MUX_tgt), .WE_pc(WE_pc),
        .MUX_pc(MUX_pc), .FUNC_alu(FUNC_alu), .MUX_alu2(MUX_alu2),
        .rA(rA), .rB(rB), .rC(rC), .simm7(simm7), .imm10(imm10),
        .halted(halted), .instr_count(instr_count)
    );

    risc16_control #(.CNT_W(4), .HALT_EN(1'b0)) dut4 (
        .clk(clk), .rst(rst), .ir_in(ir_in), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .alu_eq(alu_eq),
        .imem_req(imem_req4), .dmem_req(dmem_req4), .dmem_we(dmem_we4),
        .WE_rf(WE_rf4), .MUX_rf(MUX_rf4), .MUX_tgt(MUX_tgt4), .WE_pc(WE_pc4),
        .MUX_pc(MUX_pc4), .FUNC_alu(FUNC_alu4), .MUX_alu2(MUX_alu24),
        .rA(rA4), .rB(rB4), .rC(rC4), .simm7(simm74), .imm10(imm104),
        .halted(halted4), .instr_count(instr_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in FETCH with imem_ready high, leaving the bench in DECODE.
    task automatic fetch(input logic [15:0] w);
        imem_ready = 1'b1;
        ir_in      = w;
        #1;
        chk("fetch_imem_req", 32'(imem_req), 32'd1);
        chk("fetch_we_pc", 32'(WE_pc), 32'd1);
        chk("fetch_mux_pc", 32'(MUX_pc), 32'd0);
        next_cycle();
        imem_ready = 1'b0;
        ir_in      = 16'h0000;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        ir_in      = 16'h0000;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_eq     = 1'b0;
        repeat (2) next_cycle();

        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_we_pc", 32'(WE_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_rA", 32'(rA), 32'd0);

        // ADDI r1,r0,5 : F D E WB
        rst = 1'b0;
        fetch(16'h2405);
        chk("addi_dec_we_rf", 32'(WE_rf), 32'd0);
        chk("addi_dec_imem_req", 32'(imem_req), 32'd0);
        next_cycle();
        chk("addi_exec_func", 32'(FUNC_alu), 32'd0);
        chk("addi_exec_alu2", 32'(MUX_alu2), 32'd1);
        chk("addi_exec_we_rf", 32'(WE_rf), 32'd0);
        next_cycle();
        chk("addi_wb_we_rf", 32'(WE_rf), 32'd1);
        chk("addi_wb_tgt", 32'(MUX_tgt), 32'd1);
        chk("addi_wb_rA", 32'(rA), 32'd1);
        chk("addi_wb_simm7", 32'(simm7), 32'h0005);
        next_cycle();
        chk("addi_count", 32'(instr_count), 32'd1);

        // FETCH stalls without imem_ready
        #1;
        chk("stall_imem_req", 32'(imem_req), 32'd1);
        chk("stall_we_pc", 32'(WE_pc), 32'd0);
        next_cycle();

        // LW r2,r1,-1 with three data-wait cycles
        fetch(16'hA8FF);
        chk("lw_dec_mux_rf", 32'(MUX_rf), 32'd0);
        next_cycle();
        chk("lw_exec_alu2", 32'(MUX_alu2), 32'd1);
        next_cycle();
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            dmem_ready = (i == 3);
            #1;
            if (dmem_req) req_cycles++;
            chk("lw_mem_we", 32'(dmem_we), 32'd0);
            next_cycle();
            if (i == 3) break;
        end
        dmem_ready = 1'b0;
        chk("lw_dmem_req_cycles", 32'(req_cycles), 32'd4);
        chk("lw_wb_we_rf", 32'(WE_rf), 32'd1);
        chk("lw_wb_tgt", 32'(MUX_tgt), 32'd0);
        chk("lw_wb_rA", 32'(rA), 32'd2);
        chk("lw_wb_simm7", 32'(simm7), 32'hFFFF);
        chk("lw_wb_dmem_req", 32'(dmem_req), 32'd0);
        next_cycle();
        chk("lw_count", 32'(instr_count), 32'd2);

        // BEQ r1,r1,+3 taken
        fetch(16'hC483);
        chk("beq_dec_mux_rf", 32'(MUX_rf), 32'd1);
        next_cycle();
        alu_eq = 1'b1;
        #1;
        chk("beq_t_we_pc", 32'(WE_pc), 32'd1);
        chk("beq_t_mux_pc", 32'(MUX_pc), 32'd1);
        chk("beq_t_func", 32'(FUNC_alu), 32'd3);
        next_cycle();
        alu_eq = 1'b0;
        chk("beq_t_count", 32'(instr_count), 32'd3);
        chk("beq_t_back_to_fetch", 32'(imem_req), 32'd1);

        // BEQ not taken
        fetch(16'hC483);
        next_cycle();
        #1;
        chk("beq_nt_we_pc", 32'(WE_pc), 32'd0);
        next_cycle();
        chk("beq_nt_count", 32'(instr_count), 32'd4);

        // JALR r7,r3,0
        fetch(16'hFD80);
        chk("jalr_dec_halted", 32'(halted), 32'd0);
        next_cycle();
        chk("jalr_exec_we_pc", 32'(WE_pc), 32'd0);
        next_cycle();
        chk("jalr_wb_we_rf", 32'(WE_rf), 32'd1);
        chk("jalr_wb_tgt", 32'(MUX_tgt), 32'd2);
        chk("jalr_wb_we_pc", 32'(WE_pc), 32'd1);
        chk("jalr_wb_mux_pc", 32'(MUX_pc), 32'd2);
        next_cycle();
        chk("jalr_count", 32'(instr_count), 32'd5);

        // ADD r0,r1,r2 : write to r0 suppressed
        fetch(16'h0082);
        next_cycle();
        next_cycle();
        chk("add_r0_we_rf", 32'(WE_rf), 32'd0);
        chk("add_r0_tgt", 32'(MUX_tgt), 32'd1);
        next_cycle();
        chk("add_r0_count", 32'(instr_count), 32'd6);

        // SW r1,r2,1 zero-wait
        fetch(16'h8501);
        chk("sw_dec_mux_rf", 32'(MUX_rf), 32'd1);
        next_cycle();
        next_cycle();
        dmem_ready = 1'b1;
        #1;
        chk("sw_mem_req", 32'(dmem_req), 32'd1);
        chk("sw_mem_we", 32'(dmem_we), 32'd1);
        chk("sw_mem_we_rf", 32'(WE_rf), 32'd0);
        next_cycle();
        dmem_ready = 1'b0;
        chk("sw_count", 32'(instr_count), 32'd7);
        chk("sw_count4", 32'(instr_count4), 32'd7);

        // Reset during a data wait; rst wins over dmem_ready
        fetch(16'hA8FF);
        next_cycle();
        next_cycle();
        chk("rstmem_req_before", 32'(dmem_req), 32'd1);
        rst        = 1'b1;
        dmem_ready = 1'b1;
        next_cycle();
        chk("rstmem_dmem_req", 32'(dmem_req), 32'd0);
        chk("rstmem_imem_req", 32'(imem_req), 32'd0);
        chk("rstmem_we_rf", 32'(WE_rf), 32'd0);
        chk("rstmem_count", 32'(instr_count), 32'd0);
        chk("rstmem_count4", 32'(instr_count4), 32'd0);
        rst        = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("rstmem_fetch", 32'(imem_req), 32'd1);

        // Counter wrap on the 4-bit twin
        for (int i = 0; i < 16; i++) begin
            fetch(16'hC483);
            next_cycle();
            next_cycle();
            if (i == 14) begin
                chk("wrap_count_15", 32'(instr_count), 32'd15);
                chk("wrap_count4_15", 32'(instr_count4), 32'd15);
            end
        end
        chk("wrap_count_16", 32'(instr_count), 32'h10);
        chk("wrap_count4_0", 32'(instr_count4), 32'd0);

        // HALT encoding; twin has HALT_EN=0 and proceeds to EXEC
        fetch(16'hE001);
        chk("halt_dec_halted", 32'(halted), 32'd0);
        next_cycle();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt4_halted", 32'(halted4), 32'd0);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (3) next_cycle();
        chk("halt_stays", 32'(halted), 32'd1);
        chk("halt_imem_req", 32'(imem_req), 32'd0);
        chk("halt_we_pc", 32'(WE_pc), 32'd0);
        chk("halt_dmem_req", 32'(dmem_req), 32'd0);
        chk("halt_no_count", 32'(instr_count), 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
